// File: rtl/stack_pkg.sv
// ============================================================================
//  Module      : stack_pkg
//  Description : Shared definitions for the stack and its reader. Holds the
//                default data width, the default drain depth and the reader
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stack_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    // Reader FSM states, encoded with an explicit width
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_CAP  = 3'd2,
        ST_OUT  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage : stack_pkg

`default_nettype wire

// File: rtl/stack_reader.sv
// ============================================================================
//  Module      : stack_reader
//  Description : Drains a requested number of entries from a stack, one pop
//                at a time, and hands each entry downstream over a
//                valid/ready link. A stack error aborts the drain and raises
//                a sticky error flag. Every drain ends with a one-cycle done.
//  Options     : STACK_READER_CHECKSUM_EN - when defined, checksum carries a
//                running XOR of all entries transferred in the current drain;
//                when undefined, checksum is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_reader
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      count,
    output logic                  pop,
    input  logic [DATA_WIDTH-1:0] stk_data,
    input  logic                  stk_error,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error_out,
    output logic [DATA_WIDTH-1:0] checksum
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining;
    logic             start_accept;
    logic             transfer;

    // start is only honoured while idle; anything arriving mid-drain is dropped
    assign start_accept = (state == ST_IDLE) && start;
    assign transfer     = (state == ST_OUT) && m_ready;

    // State register; reset abandons any drain in progress immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (count != '0) ? ST_POP : ST_FIN;
                end
            end
            ST_POP:  state_next = ST_CAP;
            ST_CAP:  state_next = stk_error ? ST_FIN : ST_OUT;
            ST_OUT: begin
                // remaining was already decremented in POP, so zero here
                // means the entry being offered is the last one
                if (m_ready) begin
                    state_next = (remaining != '0) ? ST_POP : ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state alone, so reset clears them at once
    always_comb begin
        pop     = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            ST_IDLE: busy    = 1'b0;
            ST_POP:  pop     = 1'b1;
            ST_OUT:  m_valid = 1'b1;
            ST_FIN:  done    = 1'b1;
            default: ;
        endcase
    end

    // Entries still to pop; the zero guard keeps it from ever wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
        end else if (start_accept) begin
            remaining <= count;
        end else if ((state == ST_POP) && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Output register: captures the popped entry unless the stack flagged an error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= '0;
        end else if ((state == ST_CAP) && !stk_error) begin
            m_data <= stk_data;
        end
    end

    // Sticky abort flag, cleared only by the next accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_out <= 1'b0;
        end else if (start_accept) begin
            error_out <= 1'b0;
        end else if ((state == ST_CAP) && stk_error) begin
            error_out <= 1'b1;
        end
    end

`ifdef STACK_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_acc;

    // Running XOR of every entry handed downstream during this drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_acc <= '0;
        end else if (start_accept) begin
            checksum_acc <= '0;
        end else if (transfer) begin
            checksum_acc <= checksum_acc ^ m_data;
        end
    end

    assign checksum = checksum_acc;
`else
    assign checksum = '0;
`endif

endmodule : stack_reader

`default_nettype wire

// File: tb/tb_stack_reader.sv
// ============================================================================
//  Module      : tb_stack_reader
//  Description : Self-checking bench for stack_reader. A queue-based stack
//                model feeds the reader; each drain's expected transfers,
//                pop count, error flag and checksum are derived from the
//                stack contents and requested count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic          pop;
    logic [DW-1:0] stk_data = '0;
    logic          stk_error = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          error_out;
    logic [DW-1:0] checksum;

    int n_vec = 0;
    int n_err = 0;

    stack_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .pop       (pop),
        .stk_data  (stk_data),
        .stk_error (stk_error),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done),
        .error_out (error_out),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stack model: data (or an underflow error) appears the cycle after pop
    logic [DW-1:0] stack_q[$];
    always @(posedge clk) begin
        if (pop) begin
            if (stack_q.size() != 0) begin
                stk_data  <= stack_q.pop_back();
                stk_error <= 1'b0;
            end else begin
                stk_error <= 1'b1;
            end
        end else begin
            stk_error <= 1'b0;
        end
    end

    // Cycle counter and monitor (sampled on the falling edge)
    int            cyc = 0;
    int            pops = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic [DW-1:0] xfers[$];
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (pop)                 pops++;
            if (m_valid && m_ready)  xfers.push_back(m_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                check("valid_hold", m_valid, 1);
                check("data_hold", m_data, prev_data);
            end
            if (busy) check("pop_excl", pop & m_valid, 0);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // One drain: predict the outcome from the stack contents, run it, compare
    task automatic run_drain(input string name, input int n, input int pct,
                             input int hold, input bit reissue);
        int            size      = stack_q.size();
        int            n_ok      = (n < size) ? n : size;
        bit            exp_err   = (n > size);
        int            exp_pops  = exp_err ? size + 1 : n;
        logic [DW-1:0] exp_x[$];
        logic [DW-1:0] exp_ck    = '0;
        int            p0        = pops;
        int            d0        = done_cnt;
        int            x0        = xfers.size();
        int            hold_left = hold;
        int            c0;
        bit            finished  = 1'b0;

        for (int i = 0; i < n_ok; i++) begin
            exp_x.push_back(stack_q[size - 1 - i]);
            exp_ck ^= stack_q[size - 1 - i];
        end
`ifndef STACK_READER_CHECKSUM_EN
        exp_ck = '0;
`endif
        @(posedge clk); #1;
        start   = 1'b1;
        count   = CW'(n);
        m_ready = ($urandom_range(99) < pct);
        c0      = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        count = CW'($urandom_range(DEPTH));
        for (int k = 0; k < 400; k++) begin
            if (done_cnt != d0) begin
                finished = 1'b1;
                break;
            end
            if (reissue && k == 1) begin
                start = 1'b1;
                count = CW'(n + 2);
            end else begin
                start = 1'b0;
            end
            if (hold_left > 0 && m_valid) begin
                m_ready = 1'b0;
                hold_left--;
            end else begin
                m_ready = ($urandom_range(99) < pct);
            end
            @(posedge clk); #1;
        end
        start   = 1'b0;
        m_ready = 1'b0;
        if (!finished) check({name, "_timeout"}, 0, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_err"}, error_out, exp_err);
        check({name, "_pops"}, pops - p0, exp_pops);
        check({name, "_done"}, done_cnt - d0, 1);
        check({name, "_nxfer"}, xfers.size() - x0, n_ok);
        for (int i = 0; i < n_ok && (x0 + i) < xfers.size(); i++)
            check({name, "_data"}, xfers[x0 + i], exp_x[i]);
        check({name, "_cksum"}, checksum, exp_ck);
        // start is sampled on the next edge and FIN occupies the cycle after it
        if (n == 0) check({name, "_done_lat"}, done_cyc - c0, 1);
    endtask

    initial begin
        int p0;
        int d0;
        bit seen;

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("rst_pop", pop, 0);
        check("rst_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", error_out, 0);
        check("rst_data", m_data, 0);
        check("rst_cksum", checksum, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic LIFO drain
        stack_q = '{8'h11, 8'h22, 8'h33};
        run_drain("basic", 3, 100, 0, 1'b0);

        // Downstream back-pressure
        stack_q = '{8'h5A, 8'hA5, 8'h3C};
        run_drain("stall", 2, 100, 5, 1'b0);

        // Stack underflow aborts the drain
        stack_q = '{8'h77};
        run_drain("abort", 3, 100, 0, 1'b0);

        // Zero-length drain clears the error flag left by the abort
        stack_q.delete();
        run_drain("zero", 0, 100, 0, 1'b0);

        // Reset during OUT
        stack_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        @(posedge clk); #1;
        start = 1'b1; count = CW'(4); m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rst_mid_reach_out", seen, 1);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", m_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pop", pop, 0);
        check("rst_mid_data", m_data, 0);
        @(posedge clk); #3;
        reset = 1'b0;
        p0 = pops;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_no_pop", pops - p0, 0);
        check("rst_mid_no_done", done_cnt - d0, 0);
        stack_q = '{8'hC3};
        run_drain("post_rst", 1, 100, 0, 1'b0);

        // start re-asserted while busy is ignored
        stack_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        run_drain("reissue", 2, 100, 0, 1'b1);

        // Randomized drains
        for (int t = 0; t < 25; t++) begin
            int  n    = $urandom_range(0, 6);
            int  size = $urandom_range(0, 6);
            int  pct;
            case ($urandom_range(2))
                0:       pct = 100;
                1:       pct = 50;
                default: pct = 25;
            endcase
            stack_q.delete();
            for (int i = 0; i < size; i++) stack_q.push_back(DW'($urandom));
            run_drain("rand", n, pct, $urandom_range(0, 3),
                      (n > 0) && ($urandom_range(1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stack_reader

`default_nettype wire
